// File: rtl/act_pwl_stream.sv
// Multi-lane piecewise-linear activation (sigmoid, tanh, ReLU, bypass) on a 3-stage valid/ready pipeline.
// Tanh reuses the sigmoid curve through tanh(x) = 2*sigmoid(2x) - 1, so stage 1 doubles |x| for tanh.
module act_pwl_stream #(
   parameter int LANES   = 2,
   parameter int DATA_W  = 8,
   parameter int FRAC_IN = 4,
   parameter int OUT_W   = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_mode,
   input  logic [LANES*DATA_W-1:0]  x_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*OUT_W-1:0]   y_out,
   output logic [1:0]               out_mode,
   output logic [15:0]              sample_count
);

   localparam int MW = DATA_W + 1;
   localparam int SW = OUT_W + 1;
   localparam int AW = DATA_W + OUT_W + 9;
   localparam int CW = DATA_W + OUT_W + 3;
   localparam int FS = FRAC_IN + 5;

   // Segment breakpoints in input units; offsets carry FS fractional bits.
   localparam logic [AW-1:0] M_ONE   = AW'(1) << FRAC_IN;
   localparam logic [AW-1:0] M_KNEE  = AW'(19) << (FRAC_IN - 3);
   localparam logic [AW-1:0] M_SAT   = AW'(5) << FRAC_IN;
   localparam logic [AW-1:0] C_LO    = AW'(1) << (FS - 1);
   localparam logic [AW-1:0] C_MID   = AW'(5) << (FS - 3);
   localparam logic [AW-1:0] C_HI    = AW'(27) << (FS - 5);
   localparam logic [AW-1:0] S_ONE_W = AW'(1) << OUT_W;
   localparam logic [SW-1:0] S_ONE   = SW'(1) << OUT_W;
   localparam logic signed [CW-1:0] Y_MAX  = {{(CW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [CW-1:0] Y_MIN  = -Y_MAX - CW'(1);
   localparam logic signed [CW-1:0] T_MIN  = -Y_MAX;
   localparam logic signed [CW-1:0] Y_HALF = {{(CW-OUT_W){1'b0}}, 1'b1, {(OUT_W-1){1'b0}}};

   logic                 v1_q, v2_q, v3_q;
   logic                 s1_en, s2_en, s3_en;
   logic [1:0]           mode1_q, mode2_q, out_mode_q;
   logic                 sign1_d [LANES];
   logic                 sign1_q [LANES];
   logic                 sign2_q [LANES];
   logic [MW-1:0]        abs1    [LANES];
   logic [MW-1:0]        mag1_d  [LANES];
   logic [MW-1:0]        mag1_q  [LANES];
   logic [MW-1:0]        mag2_q  [LANES];
   logic [AW-1:0]        m2      [LANES];
   logic [AW-1:0]        lin2    [LANES];
   logic [AW-1:0]        scl2    [LANES];
   logic [SW-1:0]        s2_d    [LANES];
   logic [SW-1:0]        s2_q    [LANES];
   logic [SW-1:0]        q3      [LANES];
   logic signed [CW-1:0] t3      [LANES];
   logic signed [CW-1:0] rx3     [LANES];
   logic [LANES*OUT_W-1:0] y_d, y_out_q;
   logic [15:0]          cnt_q;

   assign s3_en    = !v3_q || out_ready;
   assign s2_en    = !v2_q || s3_en;
   assign s1_en    = !v1_q || s2_en;
   assign in_ready = !reset && s1_en;

   assign out_valid    = v3_q;
   assign y_out        = y_out_q;
   assign out_mode     = out_mode_q;
   assign sample_count = cnt_q;

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         sign1_d[l] = x_in[l*DATA_W + DATA_W - 1];
         abs1[l]    = sign1_d[l] ? -{sign1_d[l], x_in[l*DATA_W +: DATA_W]}
                                 :  {sign1_d[l], x_in[l*DATA_W +: DATA_W]};
         mag1_d[l]  = (in_mode == 2'd1) ? {abs1[l][MW-2:0], 1'b0} : abs1[l];
      end
   end

   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         m2[l] = {{(AW-MW){1'b0}}, mag1_q[l]};
         if (m2[l] < M_ONE) begin
            lin2[l] = (m2[l] << 3) + C_LO;
         end else if (m2[l] < M_KNEE) begin
            lin2[l] = (m2[l] << 2) + C_MID;
         end else begin
            lin2[l] = m2[l] + C_HI;
         end
         scl2[l] = (lin2[l] << OUT_W) >> FS;
         s2_d[l] = (m2[l] >= M_SAT || scl2[l] > S_ONE_W) ? S_ONE : scl2[l][SW-1:0];
      end
   end

   always_comb begin
      y_d = '0;
      for (int l = 0; l < LANES; l++) begin
         q3[l]  = sign2_q[l] ? (S_ONE - s2_q[l]) : s2_q[l];
         t3[l]  = $signed({{(CW-SW){1'b0}}, q3[l]}) - Y_HALF;
         rx3[l] = sign2_q[l] ? -$signed({{(CW-MW){1'b0}}, mag2_q[l]})
                             :  $signed({{(CW-MW){1'b0}}, mag2_q[l]});
         case (mode2_q)
            2'd0: y_d[l*OUT_W +: OUT_W] = q3[l][OUT_W] ? {OUT_W{1'b1}} : q3[l][OUT_W-1:0];
            2'd1: begin
               if (t3[l] > Y_MAX)      y_d[l*OUT_W +: OUT_W] = Y_MAX[OUT_W-1:0];
               else if (t3[l] < T_MIN) y_d[l*OUT_W +: OUT_W] = T_MIN[OUT_W-1:0];
               else                    y_d[l*OUT_W +: OUT_W] = t3[l][OUT_W-1:0];
            end
            default: begin
               // ReLU and bypass share the saturating resize; ReLU just zeroes negatives.
               if (mode2_q == 2'd2 && sign2_q[l]) y_d[l*OUT_W +: OUT_W] = '0;
               else if (rx3[l] > Y_MAX)           y_d[l*OUT_W +: OUT_W] = Y_MAX[OUT_W-1:0];
               else if (rx3[l] < Y_MIN)           y_d[l*OUT_W +: OUT_W] = Y_MIN[OUT_W-1:0];
               else                               y_d[l*OUT_W +: OUT_W] = rx3[l][OUT_W-1:0];
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         v3_q       <= 1'b0;
         mode1_q    <= '0;
         mode2_q    <= '0;
         out_mode_q <= '0;
         y_out_q    <= '0;
         cnt_q      <= '0;
         for (int l = 0; l < LANES; l++) begin
            sign1_q[l] <= 1'b0;
            sign2_q[l] <= 1'b0;
            mag1_q[l]  <= '0;
            mag2_q[l]  <= '0;
            s2_q[l]    <= '0;
         end
      end else begin
         if (s1_en) v1_q <= in_valid;
         if (s1_en && in_valid) begin
            mode1_q <= in_mode;
            for (int l = 0; l < LANES; l++) begin
               sign1_q[l] <= sign1_d[l];
               mag1_q[l]  <= mag1_d[l];
            end
         end
         if (s2_en) v2_q <= v1_q;
         if (s2_en && v1_q) begin
            mode2_q <= mode1_q;
            for (int l = 0; l < LANES; l++) begin
               sign2_q[l] <= sign1_q[l];
               mag2_q[l]  <= mag1_q[l];
               s2_q[l]    <= s2_d[l];
            end
         end
         if (s3_en) v3_q <= v2_q;
         if (s3_en && v2_q) begin
            y_out_q    <= y_d;
            out_mode_q <= mode2_q;
         end
         if (v3_q && out_ready) cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule

// File: tb/tb_act_pwl_stream.sv
// Directed bench for act_pwl_stream at default parameters (2 lanes, 8-bit in Q3.4, 8-bit out).
module tb_act_pwl_stream;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  in_mode = 2'd0;
   logic [15:0] x_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] y_out;
   logic [1:0]  out_mode;
   logic [15:0] sample_count;

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;
   bit mon_en = 1'b1;

   typedef struct {
      logic [15:0] y;
      logic [1:0]  m;
      int          e;
   } rec_t;

   rec_t out_q[$];
   int   in_e[$];

   act_pwl_stream dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .x_in(x_in), .out_valid(out_valid), .out_ready(out_ready),
      .y_out(y_out), .out_mode(out_mode), .sample_count(sample_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // Handshakes seen at the falling edge complete on the following rising edge.
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         if (in_valid && in_ready) in_e.push_back(edge_cnt + 1);
         if (out_valid && out_ready) begin
            rec_t r;
            r.y = y_out;
            r.m = out_mode;
            r.e = edge_cnt + 1;
            out_q.push_back(r);
         end
      end
   end

   function automatic logic [7:0] ref_y(input logic [1:0] m, input logic [7:0] x);
      int xi, a, s, q, t;
      xi = int'($signed(x));
      a  = (xi < 0) ? -xi : xi;
      if (m == 2'd1) a = 2 * a;
      if (a < 16)      s = 4 * a + 128;
      else if (a < 38) s = 2 * a + 160;
      else if (a < 80) s = a / 2 + 216;
      else             s = 256;
      q = (xi < 0) ? 256 - s : s;
      case (m)
         2'd0: return (q > 255) ? 8'd255 : 8'(q);
         2'd1: begin
            t = q - 128;
            if (t > 127)  t = 127;
            if (t < -127) t = -127;
            return 8'(t);
         end
         2'd2: return (xi < 0) ? 8'd0 : x;
         default: return x;
      endcase
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
      out_q.delete();
      in_e.delete();
   endtask

   task automatic send(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
      bit ok = 1'b0;
      in_mode  = m;
      x_in     = {b, a};
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: in_ready stayed 0 for mode %0d x=%h", m, {b, a});
      end
   endtask

   task automatic wait_outs(input int n);
      for (int i = 0; i < 3000 && out_q.size() < n; i++) @(posedge clk);
      checks++;
      if (out_q.size() < n) begin
         failures++;
         $display("FAIL out_timeout: got %0d outputs, expected %0d", out_q.size(), n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
      checks++; if (y_out !== 16'h0) begin failures++; $display("FAIL rst_y_out: got %h expected 0000", y_out); end
      checks++; if (out_mode !== 2'd0) begin failures++; $display("FAIL rst_out_mode: got %0d expected 0", out_mode); end
      checks++; if (sample_count !== 16'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", sample_count); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_sigmoid();
      logic [7:0] xs [6];
      logic [7:0] ex [6];
      xs = '{8'h00, 8'h10, 8'hF0, 8'h28, 8'h7F, 8'h80};
      ex = '{8'h80, 8'hC0, 8'h40, 8'hEC, 8'hFF, 8'h00};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) send(2'd0, xs[i], xs[(i+1)%6]);
      wait_outs(6);
      for (int i = 0; i < 6 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i].y !== {ex[(i+1)%6], ex[i]}) begin
            failures++; $display("FAIL sigmoid_y[%0d]: got %h expected %h", i, out_q[i].y, {ex[(i+1)%6], ex[i]});
         end
         checks++;
         if (out_q[i].m !== 2'd0) begin failures++; $display("FAIL sigmoid_mode[%0d]: got %0d expected 0", i, out_q[i].m); end
         checks++;
         if (i < in_e.size() && out_q[i].e - in_e[i] !== 3) begin
            failures++; $display("FAIL sigmoid_latency[%0d]: got %0d expected 3", i, out_q[i].e - in_e[i]);
         end
      end
   endtask

   task automatic test_tanh();
      logic [7:0] xs [5];
      logic [7:0] ex [5];
      xs = '{8'h00, 8'h10, 8'hF0, 8'h7F, 8'h80};
      ex = '{8'h00, 8'h60, 8'hA0, 8'h7F, 8'h81};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) send(2'd1, xs[i], xs[(i+2)%5]);
      wait_outs(5);
      for (int i = 0; i < 5 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i].y !== {ex[(i+2)%5], ex[i]} || out_q[i].m !== 2'd1) begin
            failures++; $display("FAIL tanh[%0d]: got %h mode %0d expected %h mode 1", i, out_q[i].y, out_q[i].m, {ex[(i+2)%5], ex[i]});
         end
      end
   endtask

   task automatic test_relu_bypass();
      do_reset();
      out_ready = 1'b1;
      send(2'd2, 8'hFB, 8'd37);
      send(2'd3, 8'hFB, 8'd37);
      wait_outs(2);
      if (out_q.size() >= 2) begin
         checks++;
         if (out_q[0].y !== 16'h2500 || out_q[0].m !== 2'd2) begin
            failures++; $display("FAIL relu: got %h mode %0d expected 2500 mode 2", out_q[0].y, out_q[0].m);
         end
         checks++;
         if (out_q[1].y !== 16'h25FB || out_q[1].m !== 2'd3) begin
            failures++; $display("FAIL bypass: got %h mode %0d expected 25fb mode 3", out_q[1].y, out_q[1].m);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  xs [6];
      logic [7:0]  ex [6];
      logic [15:0] snap;
      xs = '{8'h00, 8'h10, 8'hF0, 8'h28, 8'h7F, 8'h80};
      ex = '{8'h80, 8'hC0, 8'h40, 8'hEC, 8'hFF, 8'h00};
      do_reset();
      out_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 6; i++) send(2'd0, xs[i], xs[5-i]);
         end
         begin
            repeat (5) @(posedge clk);
            @(negedge clk);
            checks++; if (in_e.size() !== 3) begin failures++; $display("FAIL bp_accepted: got %0d expected 3", in_e.size()); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
            checks++; if (y_out !== {ex[5], ex[0]}) begin failures++; $display("FAIL bp_stall_y: got %h expected %h", y_out, {ex[5], ex[0]}); end
            snap = y_out;
            @(negedge clk);
            checks++; if (y_out !== snap || out_mode !== 2'd0) begin failures++; $display("FAIL bp_hold: got %h mode %0d expected %h mode 0", y_out, out_mode, snap); end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_outs(6);
      for (int i = 0; i < 6 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i].y !== {ex[5-i], ex[i]}) begin
            failures++; $display("FAIL bp_order[%0d]: got %h expected %h", i, out_q[i].y, {ex[5-i], ex[i]});
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (sample_count !== 16'd6) begin failures++; $display("FAIL bp_count: got %0d expected 6", sample_count); end
      checks++; if (out_q.size() !== 6) begin failures++; $display("FAIL bp_no_dup: got %0d outputs expected 6", out_q.size()); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      out_ready = 1'b1;
      send(2'd0, 8'h10, 8'h10);
      send(2'd0, 8'h20, 8'h20);
      send(2'd0, 8'h30, 8'h30);
      @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || sample_count !== 16'd1) begin
         failures++; $display("FAIL mid_pre: got valid %b count %0d expected valid 1 count 1", out_valid, sample_count);
      end
      #1 reset = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_valid: got %b expected 0", out_valid); end
      checks++; if (sample_count !== 16'd0) begin failures++; $display("FAIL mid_count: got %0d expected 0", sample_count); end
      checks++; if (y_out !== 16'h0) begin failures++; $display("FAIL mid_y: got %h expected 0000", y_out); end
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      out_q.delete();
      repeat (10) @(posedge clk);
      checks++; if (out_q.size() !== 0) begin failures++; $display("FAIL mid_stale: got %0d outputs expected 0", out_q.size()); end
   endtask

   task automatic test_sweep();
      logic [17:0] exp_q[$];
      bit done = 1'b0;
      do_reset();
      out_ready = 1'b1;
      fork
         begin
            for (int m = 0; m < 4; m++) begin
               for (int c = 0; c < 256; c++) begin
                  logic [7:0] a, b;
                  a = 8'(c);
                  b = 8'(c + 77);
                  exp_q.push_back({2'(m), ref_y(2'(m), b), ref_y(2'(m), a)});
                  send(2'(m), a, b);
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      wait_outs(1024);
      for (int i = 0; i < 1024 && i < out_q.size(); i++) begin
         checks++;
         if ({out_q[i].m, out_q[i].y} !== exp_q[i]) begin
            failures++; $display("FAIL sweep[%0d]: got %h expected %h", i, {out_q[i].m, out_q[i].y}, exp_q[i]);
         end
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (sample_count !== 16'd1024) begin failures++; $display("FAIL sweep_count: got %0d expected 1024", sample_count); end
   endtask

   task automatic test_wrap();
      int  hs = 0;
      bit  seen = 1'b0;
      do_reset();
      mon_en    = 1'b0;
      out_ready = 1'b1;
      in_mode   = 2'd3;
      x_in      = '0;
      in_valid  = 1'b1;
      for (int i = 0; i < 70000 && hs < 65536; i++) begin
         @(negedge clk);
         if (hs == 65535 && !seen) begin
            seen = 1'b1;
            checks++;
            if (sample_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_max: got %h expected ffff", sample_count); end
         end
         if (out_valid && out_ready) hs++;
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clk);
      checks++; if (hs !== 65536) begin failures++; $display("FAIL wrap_handshakes: got %0d expected 65536", hs); end
      checks++; if (sample_count !== 16'h0000) begin failures++; $display("FAIL wrap_zero: got %h expected 0000", sample_count); end
      mon_en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sigmoid();
      test_tanh();
      test_relu_bypass();
      test_backpressure();
      test_reset_midstream();
      test_sweep();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/act_pwl_stream.md
Name: act_pwl_stream

Overview:
- Multi-lane, pipelined piecewise-linear activation unit with valid/ready streaming handshake.
- Successor to the fixed 8-bit sigmoid_piecewise: lane count and data widths are parametrised, and a per-transaction mode selects sigmoid, tanh, ReLU or bypass.
- Sits between the MAC array output and the next layer's input buffer.
- Throughput is 1 vector per cycle; latency is fixed at 3 cycles.

Parameters:
- LANES, 2, number of independent parallel lanes.
- DATA_W, 8, input width per lane; signed two's complement.
- FRAC_IN, 4, fractional bits of the input. Legal range: 3 <= FRAC_IN <= DATA_W-2.
- OUT_W, 8, output width per lane.

Ports:
- clk, in, 1, rising-edge clock.
- reset, in, 1, asynchronous, active-high; clears all state.
- in_valid, in, 1, input vector valid.
- in_ready, out, 1, unit can accept the input this cycle.
- in_mode, in, 2, mode: 0 sigmoid, 1 tanh, 2 ReLU, 3 bypass.
- x_in, in, LANES*DATA_W, packed inputs; lane 0 in the LSBs.
- out_valid, out, 1, output vector valid.
- out_ready, in, 1, downstream accepts the output.
- y_out, out, LANES*OUT_W, packed results; lane 0 in the LSBs.
- out_mode, out, 2, mode that travelled with this result.
- sample_count, out, 16, count of completed output handshakes; wraps modulo 2^16.

Behaviour:
- Reset values: out_valid=0, y_out=0, out_mode=0, sample_count=0, all stage valids=0. in_ready is high whenever reset is low and stage 1 can accept.
- Reset asserted mid-stream flushes every in-flight vector. No output is produced for those vectors.
- Pipeline: 3 register stages, each holding a valid bit.
  - A stage advances when its downstream stage is empty or advancing.
  - in_ready = !v1 || stage-1 advancing. in_ready is combinational from out_ready.
  - Input handshake = in_valid && in_ready. Output handshake = out_valid && out_ready.
- Latency: an accepted vector appears on out_valid exactly 3 cycles later when out_ready is held high.
- Stall behaviour:
  - While out_valid && !out_ready: y_out and out_mode hold stable, and nothing is lost or duplicated.
  - The pipeline can fill to 3 vectors, after which in_ready goes low.
  - Simultaneous output handshake and input handshake on a full pipe keeps throughput at 1 per cycle.
- Stage 1:
  - Registers, per lane: sign, |x|, and mode.
  - For tanh, the stored magnitude is 2|x|, with one extra bit so it cannot overflow.
  - |-2^(DATA_W-1)| is represented exactly; no wrap.
- Stage 2: computes s = PLAN sigmoid of the magnitude m, in units of 2^-OUT_W. Segments:
  - m >= 5: s = 1.
  - 2.375 <= m < 5: s = m/32 + 0.84375.
  - 1 <= m < 2.375: s = m/8 + 0.625.
  - m < 1: s = m/4 + 0.5.
  - Rounding: truncate (floor) to OUT_W fractional bits. Valid range 0 <= s <= 2^OUT_W.
- Stage 3, per mode:
  - Sigmoid: y = s for positive inputs, 2^OUT_W - s for negative inputs. Saturate to [0, 2^OUT_W-1]. Output is unsigned, Q0.OUT_W.
  - Tanh: q = s for positive inputs, 2^OUT_W - s for negative inputs. Then y = q - 2^(OUT_W-1), saturated to [-(2^(OUT_W-1)-1), 2^(OUT_W-1)-1]. Output is signed, OUT_W-1 fractional bits.
  - ReLU: y = max(x, 0), in the input format (FRAC_IN fractional bits). Sign-extend or saturate to signed OUT_W.
  - Bypass: y = x, sign-extended or saturated to signed OUT_W.
- sample_count increments on each output handshake and wraps from 0xFFFF to 0.
- Lanes are fully independent. They share only the handshake and the mode.

Test Plan:
- Sigmoid, DATA_W=8, FRAC_IN=4, out_ready=1; x = 0, 16, -16, 40, 127, -128 → y = 128, 192, 64, 236, 255, 0. Each result appears 3 cycles after its input handshake.
- Tanh; x = 0, 16, -16, 127, -128 → y = 0, 96, -96, 127, -127 (signed).
- ReLU and bypass, lane 0 = -5, lane 1 = 37 → ReLU gives {0, 37}; bypass gives {-5, 37}. out_mode matches the mode of each input.
- Back-pressure: stream 6 vectors with out_ready low for cycles 3-7 → in_ready drops after 3 accepted vectors. Outputs stay stable while stalled. All 6 results arrive in order with no loss. sample_count = 6.
- Reset mid-stream: assert reset asynchronously with 2 vectors in flight → out_valid and sample_count clear immediately, and no stale output follows reset release.
- Exhaustive sweep: all 256 input codes, all modes, random out_ready → outputs match the reference model bit-exactly. sample_count wraps 0xFFFF → 0 after 65536 handshakes.
